load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Memory stage directly downstream of the ALU.
- Consumes the ALU result as an effective address for RV32I loads and stores, or passes it through unchanged for non-memory instructions.
- Runs a single-outstanding valid/ack data-bus transaction, then presents one registered writeback beat.
- Reports misaligned, access-fault and illegal-width exceptions to the trap/CSR logic.

Parameters:
XLEN, 32, datapath and address width
BUS_TIMEOUT, 255, cycles o_bus_req may wait for i_bus_ack before an access fault is raised (8-bit counter)

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous reset, active-high
i_valid  in  1  upstream instruction valid
o_ready  out  1  stage can accept; accept = i_valid & o_ready
i_is_load  in  1  instruction is a load
i_is_store  in  1  instruction is a store
i_funct3  in  3  RV32I width/sign field
i_addr  in  XLEN  ALU result (effective address or pass-through value)
i_store_data  in  XLEN  rs2 value
i_rd_addr  in  5  destination register
i_rd_we  in  1  destination write enable for pass-through instructions
o_bus_req  out  1  bus request
o_bus_we  out  1  1 = write
o_bus_addr  out  XLEN  word-aligned address ({addr[XLEN-1:2],2'b00})
o_bus_wdata  out  XLEN  lane-replicated store data
o_bus_wstrb  out  4  byte strobes (all 0 on reads)
i_bus_ack  in  1  transaction complete
i_bus_rdata  in  XLEN  read word, valid with ack
o_wb_valid  out  1  one-cycle writeback beat
o_wb_we  out  1  register-file write enable
o_wb_rd  out  5  destination register
o_wb_data  out  XLEN  writeback value
o_exc_valid  out  1  exception, coincident with o_wb_valid
o_exc_cause  out  4  mcause code
o_exc_tval  out  XLEN  faulting address

Behaviour:
- Reset: every output 0 on the first edge with i_rst high; o_ready=0 while i_rst is high; state=IDLE; timeout counter=0.
- FSM states:
  - IDLE: o_ready=1.
  - BUS: o_ready=0; o_bus_req=1; address, we, wdata and wstrb held stable.
  - RESP: o_ready=0; wb/exc outputs driven for exactly one cycle, then return to IDLE. RESP→IDLE costs a bubble; single-issue throughput is acceptable.
- Pass-through (accept with neither i_is_load nor i_is_store):
  - Next cycle o_wb_valid=1, o_wb_data=i_addr, o_wb_we=i_rd_we, o_wb_rd=i_rd_addr.
  - Latency 1; no RESP bubble: stays IDLE with o_ready=1, back-to-back accepts allowed.
- Legal funct3 values:
  - Loads: 0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU.
  - Stores: 0 SB, 1 SH, 2 SW.
- Illegal funct3, or both i_is_load and i_is_store set:
  - Next cycle o_wb_valid=1, o_exc_valid=1, cause 2, o_exc_tval=0, o_wb_we=0.
  - No bus request.
- Misalignment:
  - Conditions: halfword with addr[0]=1; word with addr[1:0]≠0.
  - Next cycle exception beat: cause 4 (load) or 6 (store), o_exc_tval=i_addr, o_wb_we=0.
  - No bus request.
- Aligned access:
  - The accept edge registers bus outputs and enters BUS.
  - The first edge sampling i_bus_ack=1 enters RESP and drops o_bus_req.
  - Minimum latency: accept at N, ack at N+1, o_wb_valid at N+2.
- Store lanes:
  - SB: wstrb=1<<addr[1:0], wdata={4{byte}}.
  - SH: wstrb=4'b0011 (addr[1]=0) or 4'b1100 (addr[1]=1), wdata={2{half}}.
  - SW: wstrb=4'b1111.
  - Store completion beat has o_wb_we=0.
- Load extraction:
  - Byte lane addr[1:0]; half lane addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - o_wb_we=1 and o_wb_rd=i_rd_addr, even when rd=0; the register file ignores x0.
- Timeout:
  - Counter increments each BUS cycle without ack.
  - When it reaches BUS_TIMEOUT: drop req, enter RESP with cause 5 (load) or 7 (store), tval=address, o_wb_we=0.
  - Ack on the same cycle as the limit wins (normal completion).
- i_bus_ack outside BUS is ignored.
- Reset mid-transaction: o_bus_req low on the next edge; a late ack after reset is ignored.
- i_valid while o_ready=0: no effect; upstream must hold the instruction.

Decomposition:
- Shared constants in header.vh alongside XLEN and ALUOPS:
  - funct3 width codes.
  - Exception cause codes 2/4/5/6/7.
  - FSM state encodings.
- One combinational sub-module, load_store_align:
  - Store side: wstrb/wdata generation.
  - Load side: lane select plus sign/zero extension.
  - Unit-testable on its own.

Test Plan:
- Pass-through: accept i_addr=0x0000_1234, rd=5, rd_we=1 → next cycle wb_valid=1, data=0x0000_1234, we=1, rd=5; no bus_req.
- LB at 0x103, rdata=0x80FF_0000 at ack N+1 → wb_data=0xFFFF_FF80 at N+2. LBU at the same address → 0x0000_0080.
- SH at 0x202, data=0x0000_ABCD, ack after 3 wait cycles → bus_addr=0x200, wstrb=4'b1100, wdata=0xABCD_ABCD; wb_valid with we=0 on the cycle after ack.
- LW at 0x0000_0006 → exc_valid=1, cause=4, tval=0x6, no bus_req. SW at 0x1 → cause 6.
- Load at 0x400 with ack never asserted, BUS_TIMEOUT=4 → req high 4 cycles, then exc cause 5, tval=0x400. A second test asserts ack on the 4th cycle → normal completion.
- i_rst pulsed during BUS → req low next edge; a subsequent stray ack is ignored; wb_valid stays 0.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// Shared constants for the load/store unit: funct3 width codes,
// mcause exception codes, FSM state encoding and decode helpers.
package load_store_unit_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  localparam logic [3:0] CAUSE_ILLEGAL     = 4'd2;
  localparam logic [3:0] CAUSE_LD_MISALIGN = 4'd4;
  localparam logic [3:0] CAUSE_LD_FAULT    = 4'd5;
  localparam logic [3:0] CAUSE_ST_MISALIGN = 4'd6;
  localparam logic [3:0] CAUSE_ST_FAULT    = 4'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_RESP = 2'd2
  } lsu_state_e;

  // Stores only have byte/half/word; loads add the unsigned variants.
  function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
    if (is_store) return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  // funct3[1:0] encodes access size for every legal width.
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lo);
    case (f3[1:0])
      2'd1:    return lo[0];
      2'd2:    return lo != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// Byte-lane steering: store strobe/data replication and load lane
// selection with sign or zero extension. Purely combinational.
module load_store_align
  import load_store_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      i_st_funct3,
  input  logic [1:0]      i_st_addr_lo,
  input  logic [XLEN-1:0] i_st_data,
  output logic [3:0]      o_wstrb,
  output logic [XLEN-1:0] o_wdata,
  input  logic [2:0]      i_ld_funct3,
  input  logic [1:0]      i_ld_addr_lo,
  input  logic [XLEN-1:0] i_ld_rdata,
  output logic [XLEN-1:0] o_ld_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Store side: replicate the datum across lanes, strobe the addressed ones.
  always_comb begin
    o_wstrb = 4'b0000;
    o_wdata = i_st_data;
    case (i_st_funct3)
      F3_B: begin
        o_wstrb = 4'b0001 << i_st_addr_lo;
        o_wdata = {4{i_st_data[7:0]}};
      end
      F3_H: begin
        o_wstrb = i_st_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_wdata = {2{i_st_data[15:0]}};
      end
      F3_W:    o_wstrb = 4'b1111;
      default: ;
    endcase
  end

  // Load side: pick the addressed byte and halfword lanes.
  always_comb begin
    case (i_ld_addr_lo)
      2'd0:    w_byte = i_ld_rdata[7:0];
      2'd1:    w_byte = i_ld_rdata[15:8];
      2'd2:    w_byte = i_ld_rdata[23:16];
      default: w_byte = i_ld_rdata[31:24];
    endcase
    w_half = i_ld_addr_lo[1] ? i_ld_rdata[31:16] : i_ld_rdata[15:0];
  end

  // Load side: extend the selected lane to full width.
  always_comb begin
    case (i_ld_funct3)
      F3_B:    o_ld_data = {{24{w_byte[7]}}, w_byte};
      F3_H:    o_ld_data = {{16{w_half[15]}}, w_half};
      F3_BU:   o_ld_data = {24'd0, w_byte};
      F3_HU:   o_ld_data = {16'd0, w_half};
      default: o_ld_data = i_ld_rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory stage: single-outstanding bus access for loads/stores, 1-cycle
// pass-through for everything else, registered writeback/exception beat.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int BUS_TIMEOUT = 255
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic            i_is_load,
  input  logic            i_is_store,
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_addr,
  input  logic [XLEN-1:0] i_store_data,
  input  logic [4:0]      i_rd_addr,
  input  logic            i_rd_we,
  output logic            o_bus_req,
  output logic            o_bus_we,
  output logic [XLEN-1:0] o_bus_addr,
  output logic [XLEN-1:0] o_bus_wdata,
  output logic [3:0]      o_bus_wstrb,
  input  logic            i_bus_ack,
  input  logic [XLEN-1:0] i_bus_rdata,
  output logic            o_wb_valid,
  output logic            o_wb_we,
  output logic [4:0]      o_wb_rd,
  output logic [XLEN-1:0] o_wb_data,
  output logic            o_exc_valid,
  output logic [3:0]      o_exc_cause,
  output logic [XLEN-1:0] o_exc_tval
);

  lsu_state_e r_state, w_state_nxt;
  logic [7:0] r_cnt;

  // Instruction context kept for the duration of a bus access.
  logic            r_is_store;
  logic [2:0]      r_funct3;
  logic [XLEN-1:0] r_addr;
  logic [4:0]      r_rd;

  logic            r_bus_req, r_bus_we, r_wb_valid, r_wb_we, r_exc_valid;
  logic [XLEN-1:0] r_bus_addr, r_bus_wdata, r_wb_data, r_exc_tval;
  logic [3:0]      r_bus_wstrb, r_exc_cause;
  logic [4:0]      r_wb_rd;

  logic            w_bus_req, w_bus_we, w_wb_valid, w_wb_we, w_exc_valid;
  logic [XLEN-1:0] w_bus_addr, w_bus_wdata, w_wb_data, w_exc_tval;
  logic [3:0]      w_bus_wstrb, w_exc_cause;
  logic [4:0]      w_wb_rd;

  logic            w_accept, w_mem, w_illegal, w_misalign, w_bus_start, w_timeout;
  logic [3:0]      w_st_wstrb;
  logic [XLEN-1:0] w_st_wdata, w_ld_data;

  assign o_ready     = (r_state == S_IDLE) & ~i_rst;
  assign w_accept    = i_valid & o_ready;
  assign w_mem       = i_is_load | i_is_store;
  assign w_illegal   = (i_is_load & i_is_store) | ~f3_legal(i_is_store, i_funct3);
  assign w_misalign  = misaligned(i_funct3, i_addr[1:0]);
  assign w_bus_start = w_accept & w_mem & ~w_illegal & ~w_misalign;
  // Ack on the limit cycle takes priority over the fault.
  assign w_timeout   = (r_cnt == 8'(BUS_TIMEOUT - 1)) & ~i_bus_ack;

  // Store lanes come from the incoming instruction, load lanes from the
  // context latched at accept.
  load_store_align #(.XLEN(XLEN)) u_align (
    .i_st_funct3  (i_funct3),
    .i_st_addr_lo (i_addr[1:0]),
    .i_st_data    (i_store_data),
    .o_wstrb      (w_st_wstrb),
    .o_wdata      (w_st_wdata),
    .i_ld_funct3  (r_funct3),
    .i_ld_addr_lo (r_addr[1:0]),
    .i_ld_rdata   (i_bus_rdata),
    .o_ld_data    (w_ld_data)
  );

  // FSM state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state: only aligned memory ops leave IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_bus_start) w_state_nxt = S_BUS;
      S_BUS:   if (i_bus_ack | w_timeout) w_state_nxt = S_RESP;
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Next values of the registered bus and writeback outputs.
  always_comb begin
    w_bus_req   = 1'b0;
    w_bus_we    = r_bus_we;
    w_bus_addr  = r_bus_addr;
    w_bus_wdata = r_bus_wdata;
    w_bus_wstrb = r_bus_wstrb;
    w_wb_valid  = 1'b0;
    w_wb_we     = 1'b0;
    w_wb_rd     = 5'd0;
    w_wb_data   = '0;
    w_exc_valid = 1'b0;
    w_exc_cause = 4'd0;
    w_exc_tval  = '0;
    case (r_state)
      S_IDLE: if (w_accept) begin
        w_wb_rd = i_rd_addr;
        if (!w_mem) begin
          w_wb_valid = 1'b1;
          w_wb_we    = i_rd_we;
          w_wb_data  = i_addr;
        end else if (w_illegal) begin
          w_wb_valid  = 1'b1;
          w_exc_valid = 1'b1;
          w_exc_cause = CAUSE_ILLEGAL;
        end else if (w_misalign) begin
          w_wb_valid  = 1'b1;
          w_exc_valid = 1'b1;
          w_exc_cause = i_is_store ? CAUSE_ST_MISALIGN : CAUSE_LD_MISALIGN;
          w_exc_tval  = i_addr;
        end else begin
          w_bus_req   = 1'b1;
          w_bus_we    = i_is_store;
          w_bus_addr  = {i_addr[XLEN-1:2], 2'b00};
          w_bus_wdata = w_st_wdata;
          w_bus_wstrb = i_is_store ? w_st_wstrb : 4'b0000;
        end
      end
      S_BUS: begin
        w_wb_rd = r_rd;
        if (i_bus_ack) begin
          w_wb_valid = 1'b1;
          w_wb_we    = ~r_is_store;
          w_wb_data  = r_is_store ? '0 : w_ld_data;
        end else if (w_timeout) begin
          w_wb_valid  = 1'b1;
          w_exc_valid = 1'b1;
          w_exc_cause = r_is_store ? CAUSE_ST_FAULT : CAUSE_LD_FAULT;
          w_exc_tval  = r_addr;
        end else begin
          w_bus_req = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Output registers, access context and wait counter.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
      r_bus_wstrb <= 4'd0;
      r_wb_valid  <= 1'b0;
      r_wb_we     <= 1'b0;
      r_wb_rd     <= 5'd0;
      r_wb_data   <= '0;
      r_exc_valid <= 1'b0;
      r_exc_cause <= 4'd0;
      r_exc_tval  <= '0;
      r_is_store  <= 1'b0;
      r_funct3    <= 3'd0;
      r_addr      <= '0;
      r_rd        <= 5'd0;
      r_cnt       <= 8'd0;
    end else begin
      r_bus_req   <= w_bus_req;
      r_bus_we    <= w_bus_we;
      r_bus_addr  <= w_bus_addr;
      r_bus_wdata <= w_bus_wdata;
      r_bus_wstrb <= w_bus_wstrb;
      r_wb_valid  <= w_wb_valid;
      r_wb_we     <= w_wb_we;
      r_wb_rd     <= w_wb_rd;
      r_wb_data   <= w_wb_data;
      r_exc_valid <= w_exc_valid;
      r_exc_cause <= w_exc_cause;
      r_exc_tval  <= w_exc_tval;
      if (w_bus_start) begin
        r_is_store <= i_is_store;
        r_funct3   <= i_funct3;
        r_addr     <= i_addr;
        r_rd       <= i_rd_addr;
      end
      if (r_state == S_BUS && !i_bus_ack) r_cnt <= r_cnt + 8'd1;
      else                                r_cnt <= 8'd0;
    end
  end

  assign o_bus_req   = r_bus_req;
  assign o_bus_we    = r_bus_we;
  assign o_bus_addr  = r_bus_addr;
  assign o_bus_wdata = r_bus_wdata;
  assign o_bus_wstrb = r_bus_wstrb;
  assign o_wb_valid  = r_wb_valid;
  assign o_wb_we     = r_wb_we;
  assign o_wb_rd     = r_wb_rd;
  assign o_wb_data   = r_wb_data;
  assign o_exc_valid = r_exc_valid;
  assign o_exc_cause = r_exc_cause;
  assign o_exc_tval  = r_exc_tval;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a spec-level expectation queue.
module tb_load_store_unit;

  localparam int T = 4;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_valid = 1'b0, i_is_load = 1'b0, i_is_store = 1'b0, i_rd_we = 1'b0;
  logic [2:0]  i_funct3 = 3'd0;
  logic [31:0] i_addr = '0, i_store_data = '0, i_bus_rdata = '0;
  logic [4:0]  i_rd_addr = 5'd0;
  logic        i_bus_ack = 1'b0;
  logic        o_ready, o_bus_req, o_bus_we, o_wb_valid, o_wb_we, o_exc_valid;
  logic [31:0] o_bus_addr, o_bus_wdata, o_wb_data, o_exc_tval;
  logic [3:0]  o_bus_wstrb, o_exc_cause;
  logic [4:0]  o_wb_rd;

  always #5 i_clk = ~i_clk;

  load_store_unit #(.XLEN(32), .BUS_TIMEOUT(T)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_is_load(i_is_load), .i_is_store(i_is_store), .i_funct3(i_funct3),
    .i_addr(i_addr), .i_store_data(i_store_data), .i_rd_addr(i_rd_addr),
    .i_rd_we(i_rd_we), .o_bus_req(o_bus_req), .o_bus_we(o_bus_we),
    .o_bus_addr(o_bus_addr), .o_bus_wdata(o_bus_wdata), .o_bus_wstrb(o_bus_wstrb),
    .i_bus_ack(i_bus_ack), .i_bus_rdata(i_bus_rdata), .o_wb_valid(o_wb_valid),
    .o_wb_we(o_wb_we), .o_wb_rd(o_wb_rd), .o_wb_data(o_wb_data),
    .o_exc_valid(o_exc_valid), .o_exc_cause(o_exc_cause), .o_exc_tval(o_exc_tval)
  );

  typedef struct {
    bit ld; bit st; bit [2:0] f3; bit [31:0] addr; bit [31:0] sdata; bit [4:0] rd; bit rdwe;
  } txn_t;

  typedef struct {
    int due; bit we; bit [4:0] rd; bit [31:0] data; bit exc; bit [3:0] cause; bit [31:0] tval;
  } beat_t;

  int checks = 0, errors = 0, cyc = 0;
  beat_t q[$];
  logic [31:0] last_data, last_tval, last_bus_addr, last_bus_wdata;
  logic [3:0]  last_cause, last_bus_wstrb;
  logic        due;

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic txn_t mk(bit ld, bit st, bit [2:0] f3, bit [31:0] addr,
                              bit [31:0] sdata, bit [4:0] rd, bit rdwe);
    txn_t t;
    t.ld = ld; t.st = st; t.f3 = f3; t.addr = addr; t.sdata = sdata; t.rd = rd; t.rdwe = rdwe;
    return t;
  endfunction

  // ---- spec-level model ----
  function automatic int nbytes(bit [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit is_illegal(txn_t t);
    if (t.ld && t.st) return 1;
    if (t.ld) return !(t.f3 == 0 || t.f3 == 1 || t.f3 == 2 || t.f3 == 4 || t.f3 == 5);
    return t.f3 > 2;
  endfunction

  function automatic bit is_misaligned(txn_t t);
    return (t.addr % nbytes(t.f3)) != 0;
  endfunction

  function automatic bit [31:0] load_val(bit [2:0] f3, bit [31:0] addr, bit [31:0] rdata);
    int n = nbytes(f3);
    bit [31:0] mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 1);
    bit [31:0] v = (rdata >> (8 * (addr % 4))) & mask;
    if (f3 < 4 && n < 4 && v[8 * n - 1]) v = v | ~mask;
    return v;
  endfunction

  function automatic bit [3:0] st_strb(bit [2:0] f3, bit [31:0] addr);
    bit [7:0] s = ((8'd1 << nbytes(f3)) - 8'd1) << (addr % 4);
    return s[3:0];
  endfunction

  function automatic bit [31:0] st_data(bit [2:0] f3, bit [31:0] d);
    case (nbytes(f3))
      1:       return {24'd0, d[7:0]} * 32'h0101_0101;
      2:       return {16'd0, d[15:0]} * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  // ---- compare process: every post-reset cycle ----
  always @(negedge i_clk) begin
    if (!i_rst) begin
      due = (q.size() > 0) && (q[0].due == cyc);
      if (o_bus_req) begin
        last_bus_addr = o_bus_addr; last_bus_wdata = o_bus_wdata; last_bus_wstrb = o_bus_wstrb;
      end
      chk("wb_valid", o_wb_valid, due);
      if (due) begin
        chk("exc_valid", o_exc_valid, q[0].exc);
        chk("wb_we", o_wb_we, q[0].we);
        if (q[0].exc) begin
          chk("exc_cause", o_exc_cause, q[0].cause);
          chk("exc_tval", o_exc_tval, q[0].tval);
        end else begin
          chk("wb_data", o_wb_data, q[0].data);
        end
        if (q[0].we) chk("wb_rd", o_wb_rd, q[0].rd);
        last_data = o_wb_data; last_cause = o_exc_cause; last_tval = o_exc_tval;
        void'(q.pop_front());
      end else begin
        chk("exc_idle", o_exc_valid, 1'b0);
      end
    end
  end

  task automatic drive(input txn_t t);
    i_valid = 1'b1; i_is_load = t.ld; i_is_store = t.st; i_funct3 = t.f3;
    i_addr = t.addr; i_store_data = t.sdata; i_rd_addr = t.rd; i_rd_we = t.rdwe;
  endtask

  // ack_wait: BUS cycle index (0-based) on which ack is raised; -1 = never.
  task automatic run(input txn_t t, input int ack_wait, input logic [31:0] rdata);
    int acc;
    bit bus, acked;
    beat_t b;
    chk("ready_idle", o_ready, 1'b1);
    drive(t);
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    acc = cyc;
    bus = (t.ld || t.st) && !is_illegal(t) && !is_misaligned(t);
    b.due = acc; b.we = 0; b.rd = t.rd; b.data = 0; b.exc = 0; b.cause = 0; b.tval = 0;
    if (!t.ld && !t.st) begin
      b.we = t.rdwe; b.data = t.addr; q.push_back(b);
    end else if (is_illegal(t)) begin
      b.exc = 1; b.cause = 2; q.push_back(b);
    end else if (is_misaligned(t)) begin
      b.exc = 1; b.cause = t.st ? 4'd6 : 4'd4; b.tval = t.addr; q.push_back(b);
    end
    if (!bus) begin
      @(negedge i_clk);
      chk("no_bus_req", o_bus_req, 1'b0);
      @(posedge i_clk); #1;
      return;
    end
    acked = 0;
    for (int n = 0; n < T; n++) begin
      @(negedge i_clk);
      chk("bus_req", o_bus_req, 1'b1);
      chk("bus_addr", o_bus_addr, t.addr & 32'hFFFF_FFFC);
      chk("bus_we", o_bus_we, t.st);
      chk("bus_wstrb", o_bus_wstrb, t.st ? st_strb(t.f3, t.addr) : 4'b0000);
      if (t.st) chk("bus_wdata", o_bus_wdata, st_data(t.f3, t.sdata));
      chk("ready_bus", o_ready, 1'b0);
      if (n == ack_wait) begin
        i_bus_ack = 1'b1; i_bus_rdata = rdata;
        b.due = acc + n + 1; b.we = t.ld;
        b.data = t.ld ? load_val(t.f3, t.addr, rdata) : 32'd0;
        q.push_back(b); acked = 1;
      end else if (n == T - 1) begin
        b.due = acc + T; b.exc = 1; b.cause = t.ld ? 4'd5 : 4'd7; b.tval = t.addr;
        q.push_back(b);
      end
      @(posedge i_clk); #1;
      i_bus_ack = 1'b0;
      if (acked) break;
    end
    @(negedge i_clk);
    chk("req_drop", o_bus_req, 1'b0);
    chk("ready_resp", o_ready, 1'b0);
    @(posedge i_clk); #1;
  endtask

  initial begin
    // reset: outputs clear on the first edge with reset high
    @(posedge i_clk); #1;
    chk("rst_ready", o_ready, 1'b0);
    chk("rst_bus_req", o_bus_req, 1'b0);
    chk("rst_wb_valid", o_wb_valid, 1'b0);
    chk("rst_exc_valid", o_exc_valid, 1'b0);
    chk("rst_bus_wstrb", o_bus_wstrb, 4'd0);
    chk("rst_wb_data", o_wb_data, 32'd0);
    i_rst = 1'b0;
    @(posedge i_clk); #1;

    // pass-through
    run(mk(0, 0, 3'd0, 32'h0000_1234, 0, 5'd5, 1), -1, 0);
    chk("pass_lit", last_data, 32'h0000_1234);

    // back-to-back pass-through, no bubble
    begin
      beat_t b;
      b.we = 1; b.exc = 0; b.cause = 0; b.tval = 0;
      drive(mk(0, 0, 3'd0, 32'hAAAA_0001, 0, 5'd7, 1));
      @(posedge i_clk); #1;
      b.due = cyc; b.rd = 5'd7; b.data = 32'hAAAA_0001; q.push_back(b);
      chk("b2b_ready", o_ready, 1'b1);
      drive(mk(0, 0, 3'd0, 32'hBBBB_0002, 0, 5'd8, 1));
      @(posedge i_clk); #1;
      b.due = cyc; b.rd = 5'd8; b.data = 32'hBBBB_0002; q.push_back(b);
      i_valid = 1'b0;
      @(posedge i_clk); #1;
    end

    // loads with byte extraction
    run(mk(1, 0, 3'd0, 32'h103, 0, 5'd3, 0), 0, 32'h80FF_0000);
    chk("lb_lit", last_data, 32'hFFFF_FF80);
    run(mk(1, 0, 3'd4, 32'h103, 0, 5'd3, 0), 0, 32'h80FF_0000);
    chk("lbu_lit", last_data, 32'h0000_0080);
    run(mk(1, 0, 3'd1, 32'h2, 0, 5'd0, 0), 1, 32'h8001_0000);
    chk("lh_lit", last_data, 32'hFFFF_8001);
    run(mk(1, 0, 3'd5, 32'h2, 0, 5'd9, 0), 0, 32'h8001_0000);
    chk("lhu_lit", last_data, 32'h0000_8001);

    // stores
    run(mk(0, 1, 3'd1, 32'h202, 32'h0000_ABCD, 5'd1, 0), 3, 0);
    chk("sh_addr_lit", last_bus_addr, 32'h200);
    chk("sh_wstrb_lit", last_bus_wstrb, 4'b1100);
    chk("sh_wdata_lit", last_bus_wdata, 32'hABCD_ABCD);
    run(mk(0, 1, 3'd0, 32'h1, 32'h0000_005A, 5'd1, 0), 0, 0);
    chk("sb_wstrb_lit", last_bus_wstrb, 4'b0010);

    // misaligned and illegal
    run(mk(1, 0, 3'd2, 32'h6, 0, 5'd4, 0), -1, 0);
    chk("lw_mis_lit", last_cause, 4'd4);
    run(mk(0, 1, 3'd2, 32'h1, 32'h1, 5'd4, 0), -1, 0);
    chk("sw_mis_lit", last_cause, 4'd6);
    run(mk(1, 0, 3'd3, 32'h40, 0, 5'd4, 0), -1, 0);
    run(mk(0, 1, 3'd4, 32'h40, 0, 5'd4, 0), -1, 0);
    run(mk(1, 1, 3'd2, 32'h40, 0, 5'd4, 0), -1, 0);
    chk("illegal_lit", last_cause, 4'd2);

    // timeout and ack on the limit cycle
    run(mk(1, 0, 3'd2, 32'h400, 0, 5'd6, 0), -1, 0);
    chk("to_cause_lit", last_cause, 4'd5);
    chk("to_tval_lit", last_tval, 32'h400);
    run(mk(1, 0, 3'd2, 32'h400, 0, 5'd6, 0), 3, 32'h1122_3344);
    chk("ack_limit_lit", last_data, 32'h1122_3344);
    run(mk(0, 1, 3'd2, 32'h8, 32'hDEAD_BEEF, 5'd6, 0), -1, 0);
    chk("st_to_lit", last_cause, 4'd7);

    // reset during BUS, then a stray ack
    drive(mk(1, 0, 3'd2, 32'h400, 0, 5'd2, 0));
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    @(posedge i_clk); #1;
    chk("mid_req", o_bus_req, 1'b1);
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    chk("mid_rst_req", o_bus_req, 1'b0);
    chk("mid_rst_ready", o_ready, 1'b0);
    chk("mid_rst_wb", o_wb_valid, 1'b0);
    i_rst = 1'b0; i_bus_ack = 1'b1; i_bus_rdata = 32'hFFFF_FFFF;
    @(posedge i_clk); #1;
    i_bus_ack = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    chk("post_rst_ready", o_ready, 1'b1);
    chk("post_rst_req", o_bus_req, 1'b0);
    chk("queue_empty", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
